// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-back source selection,
// same-cycle write-through bypass and a per-register busy scoreboard.
// Register 0 reads as zero and is never busy.
module regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NRD*AW-1:0]  rd_idx_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]     rd_busy_o,
  input  logic               wb_en_i,
  input  logic [AW-1:0]      wb_idx_i,
  input  logic [2:0]         wb_src_i,
  input  logic [XLEN-1:0]    wb_alu_i,
  input  logic [XLEN-1:0]    wb_mem_i,
  input  logic [XLEN-1:0]    wb_pc_i,
  input  logic [XLEN-1:0]    wb_imm_i,
  input  logic               wb_cmp_i,
  input  logic               sb_set_i,
  input  logic [AW-1:0]      sb_idx_i,
  output logic [XLEN-1:0]    wb_value_o,
  output logic [31:0]        retire_cnt_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] wb_value_q;
  logic [31:0]     retire_cnt_q;

  logic [XLEN-1:0] wb_val;
  logic            src_ok;
  logic            commit;
  logic            sb_hit;

  // Write-back source mux; encodings above IMM are rejected.
  always_comb begin
    wb_val = '0;
    src_ok = 1'b1;
    case (wb_src_i)
      3'b000:  wb_val = wb_alu_i;
      3'b001:  wb_val = wb_mem_i;
      3'b010:  wb_val = wb_pc_i + XLEN'(4);
      3'b011:  wb_val = {{(XLEN-1){1'b0}}, wb_cmp_i};
      3'b100:  wb_val = wb_imm_i;
      default: src_ok = 1'b0;
    endcase
  end

  // Gating with rst_ni keeps the bypass from leaking data while reset is held.
  assign commit = rst_ni & wb_en_i & (wb_idx_i != '0) & src_ok;
  assign sb_hit = sb_set_i & (sb_idx_i != '0);

  // Scoreboard next state: commit clears, a same-cycle set takes priority.
  always_comb begin
    busy_d = busy_q;
    if (commit) busy_d[wb_idx_i] = 1'b0;
    if (sb_hit) busy_d[sb_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Register array, scoreboard and write-back status state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      wb_value_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (commit) begin
        regs_q[wb_idx_i] <= wb_val;
        wb_value_q       <= wb_val;
        retire_cnt_q     <= retire_cnt_q + 32'd1;
      end
    end
  end

  // Read ports: x0 is zero, a same-cycle commit is bypassed, else storage.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_idx_i[k*AW +: AW] == '0) begin
        rd_data_o[k*XLEN +: XLEN] = '0;
        rd_busy_o[k]              = 1'b0;
      end else if (commit && (wb_idx_i == rd_idx_i[k*AW +: AW])) begin
        rd_data_o[k*XLEN +: XLEN] = wb_val;
        rd_busy_o[k]              = sb_hit && (sb_idx_i == rd_idx_i[k*AW +: AW]);
      end else begin
        rd_data_o[k*XLEN +: XLEN] = regs_q[rd_idx_i[k*AW +: AW]];
        rd_busy_o[k]              = busy_q[rd_idx_i[k*AW +: AW]];
      end
    end
  end

  assign wb_value_o   = wb_value_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic checked
// against an array-based reference model; a second small instance covers
// a 16-bit, 8-register, 3-port configuration.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Default configuration
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb_en, wb_cmp, sb_set;
  logic [4:0]  wb_idx, sb_idx;
  logic [2:0]  wb_src;
  logic [31:0] wb_alu, wb_mem, wb_pc, wb_imm;
  logic [31:0] wb_value, retire_cnt;

  // Small configuration
  logic [8:0]  s_rd_idx;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic        s_wb_en, s_wb_cmp, s_sb_set;
  logic [2:0]  s_wb_idx, s_sb_idx, s_wb_src;
  logic [15:0] s_wb_alu, s_wb_mem, s_wb_pc, s_wb_imm, s_wb_value;
  logic [31:0] s_retire_cnt;

  regfile_mp u_dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_src_i(wb_src),
    .wb_alu_i(wb_alu), .wb_mem_i(wb_mem), .wb_pc_i(wb_pc), .wb_imm_i(wb_imm),
    .wb_cmp_i(wb_cmp), .sb_set_i(sb_set), .sb_idx_i(sb_idx),
    .wb_value_o(wb_value), .retire_cnt_o(retire_cnt)
  );

  regfile_mp #(.XLEN(16), .NREG(8), .NRD(3)) u_dut_small (
    .clk_i(clk), .rst_ni(rst_n), .rd_idx_i(s_rd_idx), .rd_data_o(s_rd_data),
    .rd_busy_o(s_rd_busy), .wb_en_i(s_wb_en), .wb_idx_i(s_wb_idx),
    .wb_src_i(s_wb_src), .wb_alu_i(s_wb_alu), .wb_mem_i(s_wb_mem),
    .wb_pc_i(s_wb_pc), .wb_imm_i(s_wb_imm), .wb_cmp_i(s_wb_cmp),
    .sb_set_i(s_sb_set), .sb_idx_i(s_sb_idx), .wb_value_o(s_wb_value),
    .retire_cnt_o(s_retire_cnt)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] m_wbv;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_wbv = '0;
    m_cnt = '0;
  endtask

  // Value written for the current write-back inputs; bit 32 = source legal.
  function automatic logic [32:0] exp_wval();
    if (wb_src == 3'd0) return {1'b1, wb_alu};
    if (wb_src == 3'd1) return {1'b1, wb_mem};
    if (wb_src == 3'd2) return {1'b1, wb_pc + 32'd4};
    if (wb_src == 3'd3) return {1'b1, 31'd0, wb_cmp};
    if (wb_src == 3'd4) return {1'b1, wb_imm};
    return {1'b0, 32'd0};
  endfunction

  function automatic bit exp_commit();
    logic [32:0] w;
    w = exp_wval();
    return rst_n && wb_en && (wb_idx != 0) && w[32];
  endfunction

  task automatic check_all(input string tag);
    logic [32:0] w;
    int          idx;
    logic [31:0] ed;
    bit          eb;
    w = exp_wval();
    for (int k = 0; k < 2; k++) begin
      idx = int'(rd_idx[k*5 +: 5]);
      if (idx == 0) begin
        ed = '0; eb = 1'b0;
      end else if (exp_commit() && int'(wb_idx) == idx) begin
        ed = w[31:0];
        eb = sb_set && int'(sb_idx) == idx;
      end else begin
        ed = m_regs[idx]; eb = m_busy[idx];
      end
      chk({tag, "_rd_data"}, {32'd0, rd_data[k*32 +: 32]}, {32'd0, ed});
      chk({tag, "_rd_busy"}, {63'd0, rd_busy[k]}, {63'd0, eb});
    end
    chk({tag, "_wb_value"}, {32'd0, wb_value}, {32'd0, m_wbv});
    chk({tag, "_retire_cnt"}, {32'd0, retire_cnt}, {32'd0, m_cnt});
  endtask

  // Apply the effect of one rising edge with the inputs currently driven.
  task automatic model_update();
    logic [32:0] w;
    w = exp_wval();
    if (exp_commit()) begin
      m_regs[wb_idx] = w[31:0];
      m_wbv          = w[31:0];
      m_cnt          = m_cnt + 32'd1;
      m_busy[wb_idx] = 1'b0;
    end
    if (sb_set && sb_idx != 0) m_busy[sb_idx] = 1'b1;
  endtask

  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    wb_en = 0; wb_idx = 0; wb_src = 0; wb_alu = 0; wb_mem = 0; wb_pc = 0;
    wb_imm = 0; wb_cmp = 0; sb_set = 0; sb_idx = 0;
  endtask

  task automatic commit5(input logic [2:0] src, input logic [31:0] exp, input string tag);
    wb_en = 1; wb_idx = 5; wb_src = src;
    cycle(tag);
    wb_en = 0;
    #1;
    chk({tag, "_x5"}, {32'd0, rd_data[31:0]}, {32'd0, exp});
  endtask

  initial begin
    idle();
    rd_idx = '0;
    s_rd_idx = '0; s_wb_en = 0; s_wb_idx = 0; s_wb_src = 0; s_wb_alu = 0;
    s_wb_mem = 0; s_wb_pc = 0; s_wb_imm = 0; s_wb_cmp = 0; s_sb_set = 0; s_sb_idx = 0;
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("reset_wb_value", {32'd0, wb_value}, 64'd0);
    chk("reset_retire_cnt", {32'd0, retire_cnt}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Small instance: PC+4 wraps at 16 bits, ports read x0, x7, x7
    s_rd_idx = {3'd7, 3'd7, 3'd0};
    s_wb_en = 1; s_wb_idx = 7; s_wb_src = 3'd2; s_wb_pc = 16'hFFFE;
    #1;
    chk("small_bypass", {16'd0, s_rd_data}, {16'd0, 48'h0002_0002_0000});
    @(posedge clk);
    #1;
    s_wb_en = 0;
    #1;
    chk("small_stored", {16'd0, s_rd_data}, {16'd0, 48'h0002_0002_0000});
    chk("small_wb_value", {48'd0, s_wb_value}, 64'h2);
    chk("small_retire", {32'd0, s_retire_cnt}, 64'd1);

    // One commit per source into x5
    rd_idx = {5'd5, 5'd5};
    wb_alu = 32'h1234;      commit5(3'd0, 32'h1234, "src_alu");
    wb_mem = 32'hDEADBEEF;  commit5(3'd1, 32'hDEADBEEF, "src_mem");
    wb_pc  = 32'hFFFFFFFC;  commit5(3'd2, 32'h0, "src_pc4");
    wb_cmp = 1'b1;          commit5(3'd3, 32'h1, "src_cmp");
    wb_imm = 32'h800;       commit5(3'd4, 32'h800, "src_imm");
    chk("src_retire", {32'd0, retire_cnt}, 64'd5);

    // Bypass on both ports
    idle();
    rd_idx = {5'd7, 5'd7};
    wb_en = 1; wb_idx = 7; wb_alu = 32'hA5A5;
    #1;
    chk("byp_same", {32'd0, rd_data[63:32] ^ 32'hA5A5}, {32'd0, rd_data[31:0] ^ 32'hA5A5});
    chk("byp_p0", {32'd0, rd_data[31:0]}, 64'hA5A5);
    cycle("byp");
    wb_en = 0;
    #1;
    chk("byp_next", rd_data, 64'h0000A5A5_0000A5A5);

    // x0 write and invalid source are dropped
    rd_idx = {5'd3, 5'd0};
    wb_en = 1; wb_idx = 0; wb_alu = 32'hFFFF;
    cycle("x0_wr");
    wb_idx = 3; wb_src = 3'd7; wb_alu = 32'h5555;
    cycle("bad_src");
    wb_en = 0;
    #1;
    chk("drop_reads", rd_data, 64'd0);
    chk("drop_retire", {32'd0, retire_cnt}, 64'd6);

    // Scoreboard
    idle();
    rd_idx = {5'd9, 5'd9};
    sb_set = 1; sb_idx = 9;
    cycle("sb_set");
    sb_set = 0;
    #1;
    chk("sb_busy", {62'd0, rd_busy}, 64'd3);
    wb_en = 1; wb_idx = 9; wb_alu = 32'h99;
    #1;
    chk("sb_clr_byp", {62'd0, rd_busy}, 64'd0);
    cycle("sb_clr");
    wb_en = 0;
    #1;
    chk("sb_clr_after", {62'd0, rd_busy}, 64'd0);
    wb_en = 1; sb_set = 1; sb_idx = 9;
    cycle("sb_both");
    idle();
    #1;
    chk("sb_both_after", {62'd0, rd_busy}, 64'd3);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      wb_en  = 1'($urandom_range(0, 3) != 0);
      wb_idx = 5'($urandom_range(0, 31));
      wb_src = 3'($urandom_range(0, 7));
      wb_alu = $urandom; wb_mem = $urandom; wb_pc = $urandom; wb_imm = $urandom;
      wb_cmp = 1'($urandom_range(0, 1));
      sb_set = 1'($urandom_range(0, 1));
      sb_idx = ($urandom_range(0, 3) == 0) ? wb_idx : 5'($urandom_range(0, 31));
      for (int k = 0; k < 2; k++)
        rd_idx[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? wb_idx : 5'($urandom_range(0, 31));
      cycle("rand");
    end

    // Mid-cycle reset with a commit and set pending on the read register
    wb_en = 1; wb_idx = 12; wb_src = 3'd0; wb_alu = 32'hCAFE;
    sb_set = 1; sb_idx = 12;
    rd_idx = {5'd12, 5'd12};
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_mid_data", rd_data, 64'd0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    idle();
    rst_n = 1'b1;
    #1;
    chk("rst_after_data", rd_data, 64'd0);
    chk("rst_after_busy", {62'd0, rd_busy}, 64'd0);
    for (int n = 0; n < 20; n++) begin
      wb_en = 1; wb_idx = 5'($urandom_range(1, 31)); wb_src = 3'd4; wb_imm = $urandom;
      rd_idx = {5'($urandom_range(0, 31)), wb_idx};
      cycle("post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with integrated write-back source selection, same-cycle write-through bypass and a per-register busy scoreboard. It sits at the pipeline's decode/write-back boundary. Decode reads NRD operands and their pending-write status. Write-back commits one result per cycle, selected from ALU, memory, PC+4, comparator or immediate. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREG, 32, number of registers (power of two, ≥2); localparam AW = clog2(NREG)
- NRD, 2, number of read ports (1..4)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- rd_idx  in  NRD*AW  read indices; port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational; port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  per-port pending-write flag, combinational
- wb_en  in  1  write-back request
- wb_idx  in  AW  destination register
- wb_src  in  3  source select: 000 ALU, 001 MEM, 010 PC+4, 011 CMP, 100 IMM, others invalid
- wb_alu, wb_mem, wb_pc, wb_imm  in  XLEN each  candidate sources (wb_pc is the instruction PC)
- wb_cmp  in  1  comparator result bit
- sb_set  in  1  issue marks a destination pending
- sb_idx  in  AW  register to mark pending
- wb_value  out  XLEN  last committed value, registered
- retire_cnt  out  32  count of committed writes, registered

## Operation
- Write value by wb_src:
  - ALU → wb_alu; MEM → wb_mem; IMM → wb_imm.
  - PC+4 → wb_pc + 4, computed modulo 2^XLEN.
  - CMP → zero-extended wb_cmp: bit 0 = wb_cmp, other bits 0.
- Commit condition: wb_en & (wb_idx != 0) & valid wb_src.
- On commit:
  - regs[wb_idx] ← value; wb_value ← value; retire_cnt ← retire_cnt + 1 (wraps at 2^32).
  - busy[wb_idx] ← 0.
- wb_en with wb_idx = 0 or an invalid wb_src:
  - No register write, no wb_value update, no retire_cnt increment.
  - busy state is unaffected.
- Scoreboard:
  - sb_set & (sb_idx != 0) sets busy[sb_idx].
  - busy[0] is constant 0.
  - Same-cycle commit to X and sb_set on X: set wins, so busy[X] = 1 afterwards (a new producer supersedes the old one).
  - Commit and set on different registers: both take effect.
  - sb_set on an already-busy register: it stays busy; there is no count.
- Read port k, with idx = rd_idx[k]:
  - idx = 0 → data 0, busy 0.
  - Bypass when a commit to idx happens this cycle: data = the write value, busy = 0, unless sb_set targets idx this same cycle (then busy = 1).
  - Otherwise data = regs[idx], busy = busy[idx]. The same-cycle sb_set is not visible until the next cycle.
- All NRD ports are independent. Any number may address the same register.

## Timing
- Reset (rst low, asynchronous; takes effect immediately):
  - All regs = 0, all busy = 0, wb_value = 0, retire_cnt = 0.
  - Outputs follow combinationally: rd_data = 0, rd_busy = 0.
  - Reset asserted mid-operation discards any in-flight commit or set on that edge.
- Release of rst is synchronous to clk. The first commit can occur on the first rising edge after release.
- Write latency: the value is stored at the rising edge. The read path sees it in the same cycle through the bypass and from storage on the following cycle.
- wb_value and retire_cnt update at the commit edge and hold otherwise.
- rd_data and rd_busy depend only on the current inputs and state; there are no registered read paths.

## Test plan
- Reset: drive rst=0 mid-cycle with regs previously written → immediately rd_data=0, rd_busy=0, wb_value=0, retire_cnt=0.
- Sources, one commit per source:
  - wb_idx=5: ALU 0x1234, then MEM 0xDEADBEEF, then PC+4 with wb_pc=0xFFFFFFFC, then CMP with wb_cmp=1, then IMM 0x800.
  - reg5 reads 0x1234, 0xDEADBEEF, 0x00000000 (wrap), 0x00000001, 0x800.
  - retire_cnt=5.
- Bypass: with both ports reading x7, commit ALU 0xA5A5 to x7 → the same cycle shows rd_data=0xA5A5 on both ports, and the next cycle still shows 0xA5A5.
- x0 and invalid source:
  - Commit 0xFFFF to x0 → reads 0, retire_cnt unchanged.
  - wb_src=111 to x3 → x3 unchanged, retire_cnt unchanged.
- Scoreboard:
  - sb_set x9 → rd_busy=1 for x9 the next cycle.
  - Commit x9 → busy=0 in the same cycle (bypass) and after.
  - Simultaneous commit x9 plus sb_set x9 → busy=1 after the edge.
- Parameter sweep: XLEN=16, NREG=8, NRD=3. Three ports read x0, x7 and x7 while committing PC+4 with wb_pc=0xFFFE to x7 → results 0, 0x0002, 0x0002.
